// File: rtl/imem_loader.sv
// Byte-stream loader for instructionMemory: packs 3 bytes per instruction, writes from address 0 up to the halt word.
// Optional trailer checksum check when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int INST_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [INST_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = RECV;
          idx_d   = '0;
          addr_d  = '0;
          count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      RECV: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          // Big-endian packing; bits of byte0 above the instruction width are dropped.
          if (idx_q == 2'd0) begin
            data_d[INST_W-1:16] = in_data[INST_W-17:0];
            idx_d = 2'd1;
          end else if (idx_q == 2'd1) begin
            data_d[15:8] = in_data;
            idx_d = 2'd2;
          end else begin
            data_d[7:0] = in_data;
            idx_d   = 2'd0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        if (data_q == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else if (addr_q == '1) begin
          state_d = ERR;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset kills wr_en immediately.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR: err = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, corner sequences and a randomized load against a queue model.
// Trailer tests are built when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int ADDR_W = 12;
  localparam int INST_W = 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;
    logic [INST_W-1:0] expWord;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  wr_t gotQ[$];
  logic [INST_W-1:0] modelQ[$];
  logic [7:0] accXor;
  vec_t vecs[6];

  always @(negedge clk) if (rst_n === 1'b1 && wr_en === 1'b1) gotQ.push_back('{wr_addr, wr_data});

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [INST_W-1:0] packWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int unsigned v;
    v = (int'(b0) * 65536 + int'(b1) * 256 + int'(b2)) % (1 << INST_W);
    return v[INST_W-1:0];
  endfunction

  // Present one byte after 'gap' idle cycles and hold it until the handshake completes.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL readyTimeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      accXor = accXor ^ b;
    end
  endtask

  task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
    applyStimulus(b0, gap);
    applyStimulus(b1, gap);
    applyStimulus(b2, gap);
    @(negedge clk);
    checkOutput("wrEnLatency", wr_en, 1);
    checkOutput("readyInWrite", in_ready, 0);
  endtask

  task automatic startLoad();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gotQ.delete();
    modelQ.delete();
    accXor = 8'h00;
    checkOutput("startAddr", wr_addr, 0);
    checkOutput("startDone", done, 0);
    checkOutput("startErr", err, 0);
    checkOutput("startHold", cpu_hold, 1);
    checkOutput("startBusy", busy, 1);
    checkOutput("startCount", word_count, 0);
  endtask

  task automatic finishLoad();
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(accXor, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkDone(input int words);
    checkOutput("doneFlag", done, 1);
    checkOutput("doneErr", err, 0);
    checkOutput("doneHold", cpu_hold, 0);
    checkOutput("doneBusy", busy, 0);
    checkOutput("doneCount", word_count, words);
    checkOutput("doneAddr", wr_addr, words - 1);
  endtask

  task automatic checkWrites();
    checkOutput("writeCount", gotQ.size(), modelQ.size());
    for (int i = 0; i < gotQ.size() && i < modelQ.size(); i++) begin
      checkOutput("writeAddr", gotQ[i].addr, i);
      checkOutput("writeData", gotQ[i].data, modelQ[i]);
    end
  endtask

  task automatic checkReset();
    checkOutput("rstReady", in_ready, 0);
    checkOutput("rstWrEn", wr_en, 0);
    checkOutput("rstAddr", wr_addr, 0);
    checkOutput("rstData", wr_data, 0);
    checkOutput("rstHold", cpu_hold, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstCount", word_count, 0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b0, b1, b2;
    int n;
    vecs[0] = '{8'h04, 8'h08, 8'h64, 19'h40864};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 19'h7FFFF};
    vecs[2] = '{8'h01, 8'h00, 8'h00, 19'h10000};
    vecs[3] = '{8'h00, 8'h00, 8'h01, 19'h00001};
    vecs[4] = '{8'hAA, 8'h55, 8'hC3, 19'h255C3};
    vecs[5] = '{8'hF8, 8'h00, 8'h00, 19'h00000};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; accXor = 8'h00;
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;

    $display("[TB] table vectors");
    startLoad();
    foreach (vecs[i]) begin
      sendWord(vecs[i].b0, vecs[i].b1, vecs[i].b2, 0);
      modelQ.push_back(vecs[i].expWord);
    end
    finishLoad();
    checkWrites();
    checkDone(6);

    $display("[TB] basic stream, in_valid steady and toggling");
    for (int gap = 0; gap < 2; gap++) begin
      startLoad();
      sendWord(8'h04, 8'h08, 8'h64, gap);
      sendWord(8'h00, 8'h00, 8'h00, gap);
      finishLoad();
      modelQ.push_back(19'h40864);
      modelQ.push_back(19'h00000);
      checkWrites();
      checkDone(2);
    end

    $display("[TB] start during RECV ignored");
    startLoad();
    applyStimulus(8'h12, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignoredStartBusy", busy, 1);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h56, 0);
    @(negedge clk);
    checkOutput("ignoredStartWr", wr_en, 1);
    sendWord(8'h00, 8'h00, 8'h00, 1);
    finishLoad();
    modelQ.push_back(19'h23456);
    modelQ.push_back(19'h00000);
    checkWrites();
    checkDone(2);

    $display("[TB] reset mid-word");
    startLoad();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    startLoad();
    sendWord(8'hAB, 8'hCD, 8'hEF, 0);
    sendWord(8'h00, 8'h00, 8'h00, 0);
    finishLoad();
    modelQ.push_back(packWord(8'hAB, 8'hCD, 8'hEF));
    modelQ.push_back(19'h00000);
    checkWrites();
    checkDone(2);

    $display("[TB] randomized loads");
    for (int r = 0; r < 6; r++) begin
      startLoad();
      n = $urandom_range(1, 30);
      for (int w = 0; w < n; w++) begin
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        if (packWord(b0, b1, b2) == '0) b2 = 8'h01;
        modelQ.push_back(packWord(b0, b1, b2));
        sendWord(b0, b1, b2, $urandom_range(0, 2));
      end
      b0 = 8'($urandom) & 8'hF8;
      modelQ.push_back('0);
      sendWord(b0, 8'h00, 8'h00, $urandom_range(0, 2));
      finishLoad();
      checkWrites();
      checkDone(n + 1);
    end

    $display("[TB] memory overflow");
    startLoad();
    for (int w = 0; w < (1 << ADDR_W); w++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom) | 8'h01;
      modelQ.push_back(packWord(b0, b1, b2));
      sendWord(b0, b1, b2, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkWrites();
    checkOutput("ovfErr", err, 1);
    checkOutput("ovfDone", done, 0);
    checkOutput("ovfHold", cpu_hold, 1);
    checkOutput("ovfBusy", busy, 0);
    checkOutput("ovfReady", in_ready, 0);
    checkOutput("ovfAddr", wr_addr, (1 << ADDR_W) - 1);
    checkOutput("ovfCount", word_count, 1 << ADDR_W);

    $display("[TB] restart after ERR");
    startLoad();
    sendWord(8'h00, 8'h00, 8'h00, 0);
    finishLoad();
    modelQ.push_back('0);
    checkWrites();
    checkDone(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum trailer");
    startLoad();
    sendWord(8'h04, 8'h08, 8'h64, 0);
    sendWord(8'h00, 8'h00, 8'h00, 0);
    @(negedge clk);
    checkOutput("chkReady", in_ready, 1);
    checkOutput("chkBusy", busy, 1);
    applyStimulus(8'h68, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkDone(2);
    startLoad();
    sendWord(8'h04, 8'h08, 8'h64, 0);
    sendWord(8'h00, 8'h00, 8'h00, 0);
    applyStimulus(8'h69, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("badChkErr", err, 1);
    checkOutput("badChkDone", done, 0);
    checkOutput("badChkHold", cpu_hold, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
